// File: rtl/sevseg_mux_capture.sv
// Receive side of a multiplexed 2-digit seven-segment bus: settle, decode, commit.
// Optional hex digits A-F decode when SEVSEG_HEX_DECODE_EN is defined.
module sevseg_mux_capture #(
  parameter int SETTLE    = 2,
  parameter int STALE_MAX = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] disp_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       tens_blank,
  output logic       ones_blank,
  output logic       tens_bad,
  output logic       ones_bad,
  output logic       valid,
  output logic       upd,
  output logic       stale
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam int SW = $clog2(STALE_MAX + 1);
  localparam logic [CW-1:0] SET_MAX = CW'(SETTLE);
  localparam logic [CW-1:0] SET_PRE = CW'(SETTLE - 1);
  localparam logic [SW-1:0] STL_MAX = SW'(STALE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    HAVE_T,
    HAVE_O,
    COMMIT
  } state_t;

  // Decoded slot layout: {value[3:0], blank, bad}
  function automatic logic [5:0] dec(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'h3F:   r = {4'h0, 2'b00};
      7'h06:   r = {4'h1, 2'b00};
      7'h5B:   r = {4'h2, 2'b00};
      7'h4F:   r = {4'h3, 2'b00};
      7'h66:   r = {4'h4, 2'b00};
      7'h6D:   r = {4'h5, 2'b00};
      7'h7D:   r = {4'h6, 2'b00};
      7'h07:   r = {4'h7, 2'b00};
      7'h7F:   r = {4'h8, 2'b00};
      7'h6F:   r = {4'h9, 2'b00};
`ifdef SEVSEG_HEX_DECODE_EN
      7'h77:   r = {4'hA, 2'b00};
      7'h7C:   r = {4'hB, 2'b00};
      7'h39:   r = {4'hC, 2'b00};
      7'h5E:   r = {4'hD, 2'b00};
      7'h79:   r = {4'hE, 2'b00};
      7'h71:   r = {4'hF, 2'b00};
`endif
      7'h00:   r = {4'hF, 2'b10};
      default: r = {4'hE, 2'b01};
    endcase
    return r;
  endfunction

  logic [7:0]    disp_q, disp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stl_cnt_q, stl_cnt_d;
  state_t        state_q, state_d;
  logic [5:0]    slot_t_q, slot_t_d;
  logic [5:0]    slot_o_q, slot_o_d;
  logic [11:0]   out_q, out_d;
  logic          valid_q, valid_d;
  logic          upd_q, upd_d;
  logic          stale_q, stale_d;

  logic          chg, cap, is_t, tmo;
  logic [5:0]    dec_w;
  logic [11:0]   pair_w;

  always_comb begin
    disp_d    = disp_in;
    chg       = disp_in != disp_q;
    cap       = !chg && (cnt_q == SET_PRE);
    is_t      = disp_q[7];
    dec_w     = dec(disp_q[6:0]);
    cnt_d     = cnt_q;
    slot_t_d  = slot_t_q;
    slot_o_d  = slot_o_q;
    state_d   = state_q;
    out_d     = out_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    stale_d   = stale_q;
    pair_w    = {slot_t_q[5:2], slot_o_q[5:2],
                 slot_t_q[1], slot_o_q[1],
                 slot_t_q[0], slot_o_q[0]};

    if (chg) cnt_d = '0;
    else if (cnt_q != SET_MAX) cnt_d = cnt_q + 1'b1;

    if (cap && is_t) slot_t_d = dec_w;
    if (cap && !is_t) slot_o_d = dec_w;

    if (cap) stl_cnt_d = '0;
    else if (stl_cnt_q != STL_MAX) stl_cnt_d = stl_cnt_q + 1'b1;
    else stl_cnt_d = stl_cnt_q;
    tmo = !cap && (stl_cnt_d == STL_MAX);

    unique case (state_q)
      IDLE:   if (cap) state_d = is_t ? HAVE_T : HAVE_O;
      HAVE_T: if (cap && !is_t) state_d = COMMIT;
      HAVE_O: if (cap && is_t) state_d = COMMIT;
      COMMIT: begin
        state_d = IDLE;
        if (cap) state_d = is_t ? HAVE_T : HAVE_O;
        out_d   = pair_w;
        valid_d = 1'b1;
        upd_d   = !valid_q || (pair_w != out_q);
      end
      default: state_d = IDLE;
    endcase

    if (cap) stale_d = 1'b0;
    if (tmo) begin
      stale_d = 1'b1;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_q    <= '0;
      cnt_q     <= '0;
      stl_cnt_q <= '0;
      state_q   <= IDLE;
      slot_t_q  <= '0;
      slot_o_q  <= '0;
      out_q     <= '0;
      valid_q   <= 1'b0;
      upd_q     <= 1'b0;
      stale_q   <= 1'b0;
    end else begin
      disp_q    <= disp_d;
      cnt_q     <= cnt_d;
      stl_cnt_q <= stl_cnt_d;
      state_q   <= state_d;
      slot_t_q  <= slot_t_d;
      slot_o_q  <= slot_o_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      stale_q   <= stale_d;
    end
  end

  assign tens       = out_q[11:8];
  assign ones       = out_q[7:4];
  assign tens_blank = out_q[3];
  assign ones_blank = out_q[2];
  assign tens_bad   = out_q[1];
  assign ones_bad   = out_q[0];
  assign valid      = valid_q;
  assign upd        = upd_q;
  assign stale      = stale_q;

endmodule
